banco_registradores_param: RTL and testbench
============================================

# banco_registradores_param

Parametrised register file for the processor datapath. It generalises the 4-entry, 2-read/1-write bank to configurable word width and depth, with a second write port and write-through forwarding on both read ports. It also carries a per-register busy scoreboard, so the issue logic can reserve a destination register and detect read-after-write hazards. It sits between decode (reads and reservations) and writeback (writes).

## Interface
Parameters:
- LARGURA, 32, data word width in bits (≥1)
- NREG, 4, number of registers (power of two, ≥2)
- ZERO_FIXO, 1, when 1 register 0 always reads 0, ignores writes and cannot be reserved
- END = $clog2(NREG), derived address width (localparam)

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  asynchronous, active-high reset
- Fonte1  in  END  read address, port 1
- Fonte2  in  END  read address, port 2
- Dado1  out  LARGURA  read data, port 1
- Dado2  out  LARGURA  read data, port 2
- Ocupado1  out  1  busy bit of register Fonte1
- Ocupado2  out  1  busy bit of register Fonte2
- EscA  in  1  write enable, port A
- RegEscA  in  END  write address, port A
- DadoA  in  LARGURA  write data, port A
- EscB  in  1  write enable, port B
- RegEscB  in  END  write address, port B
- DadoB  in  LARGURA  write data, port B
- Reserva  in  1  reservation request
- RegReserva  in  END  register to reserve
- ReservaAceita  out  1  reservation granted this cycle

## Operation
- Storage: NREG × LARGURA data registers plus NREG busy bits.
- Write: on a rising edge, mem[RegEscA] ← DadoA if EscA, and mem[RegEscB] ← DadoB if EscB.
- Write conflict: EscA=EscB=1 with RegEscA=RegEscB gives port B priority; the stored value is DadoB.
- Register 0 with ZERO_FIXO=1: writes are discarded, the read value is 0, the busy bit is constantly 0, and ReservaAceita=0 for RegReserva=0.
- Read: combinational. Priority, highest first:
  - forced zero (ZERO_FIXO and address 0)
  - DadoB if EscB and RegEscB matches
  - DadoA if EscA and RegEscA matches
  - mem[address]
- Scoreboard:
  - ReservaAceita = Reserva & ~busy[RegReserva] & ~(ZERO_FIXO & RegReserva==0). This is combinational.
  - An accepted reservation sets busy[RegReserva] at the edge.
  - A write from port A or B clears the busy bit of its target at the edge.
  - An accepted reservation and a write to the same register in the same cycle leave the bit set; the reservation wins because it names a new producer.
  - A rejected reservation changes nothing. The requester must hold Reserva and retry.
- Ocupado1/2: busy bit of the addressed register, with the same-cycle write bypass applied. A write in flight to that register forces Ocupado to 0, consistent with the forwarded data.
- The contents of an unreserved register can be written; the busy bit is unaffected unless set.

## Timing
- Reset: Rst=1 asynchronously clears all data registers and busy bits. While Rst=1, Dado1=Dado2=0, Ocupado1=Ocupado2=0 and ReservaAceita=0.
- Reset mid-operation aborts pending writes and reservations. There is no recovery of state.
- Write latency: one edge for the stored value. Read-after-write in the same cycle returns the new value through the bypass (zero latency).
- Reservation: the grant is visible in the same cycle as the request. The busy bit is visible from the cycle after the edge.
- Release: a write at edge n makes Ocupado low combinationally during cycle n and registered-low from n+1.
- No handshake on writes; they are always accepted.

## Structure
- Shared package pkg_banco:
  - default LARGURA and NREG constants
  - address-width function
  - typedef palavra_t, a LARGURA-bit word
- One natural sub-module, placar_ocupado: the busy-bit scoreboard (set/clear/query, with the reservation-vs-write priority rule). It is instantiated once.
- The data array and bypass muxes stay in the top module.

## Test plan
- Reset: pulse Rst between edges after writing 0x048fc24a to r1. Required response: Dado1=0 immediately and, with Fonte1=1, Dado1=0 after reset.
- Write/read:
  - EscA to r2 with 0x00000004, then read Fonte1=2. Required: 0x00000004 next cycle.
  - Same-cycle bypass with Fonte2=2 and DadoA=0x00000006. Required: Dado2=0x00000006 before the edge.
- Dual-write conflict: EscA=EscB=1, both to r3, DadoA=0x11, DadoB=0x22. Required: r3=0x22.
- Register 0 with ZERO_FIXO=1: write 0xFFFFFFFF to r0, then read r0. Required: 0, and Reserva on r0 gives ReservaAceita=0.
- Scoreboard sequence:
  - Reserve r1. Required: ReservaAceita=1, Ocupado1=1 next cycle.
  - Reserve r1 again. Required: rejected.
  - Write r1. Required: Ocupado1=0 in the same cycle.
  - Simultaneous write and reservation to r1. Required: the bit remains 1.

Source files
------------

// File: rtl/pkg_banco.sv
// Shared definitions for the parametrised register bank.
// Provides default word width and depth, the address-width helper and the
// default data word type.
package pkg_banco;

  localparam int unsigned LARGURA_PADRAO = 32;
  localparam int unsigned NREG_PADRAO    = 4;

  typedef logic [LARGURA_PADRAO-1:0] palavra_t;

  // Address width for a bank of n registers; n is a power of two and >= 2.
  function automatic int unsigned larg_end(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/placar_ocupado.sv
// Busy-bit scoreboard for the register bank.
// Ports:
//   Clk, Rst              clock and asynchronous active-high reset
//   Fonte1, Fonte2        query addresses -> Ocupado1, Ocupado2
//   EscA/RegEscA, EscB/RegEscB   writes in flight (release the target)
//   Reserva, RegReserva   reservation request -> ReservaAceita (combinational)
module placar_ocupado
  import pkg_banco::*;
#(
  parameter int unsigned NREG      = NREG_PADRAO,
  parameter bit          ZERO_FIXO = 1'b1,
  localparam int unsigned END      = larg_end(NREG)
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic [END-1:0] Fonte1,
  input  logic [END-1:0] Fonte2,
  input  logic           EscA,
  input  logic [END-1:0] RegEscA,
  input  logic           EscB,
  input  logic [END-1:0] RegEscB,
  input  logic           Reserva,
  input  logic [END-1:0] RegReserva,
  output logic           Ocupado1,
  output logic           Ocupado2,
  output logic           ReservaAceita
);

  logic [NREG-1:0] r_ocupado;
  logic [NREG-1:0] w_prox;
  logic            w_aceita;

  assign w_aceita = Reserva & ~Rst & ~r_ocupado[RegReserva]
                  & ~(ZERO_FIXO && (RegReserva == '0));

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_prox[i] = r_ocupado[i];
      if ((EscA && (RegEscA == END'(i))) || (EscB && (RegEscB == END'(i)))) begin
        w_prox[i] = 1'b0;
      end
      // A new producer outranks the write that retires the old one.
      if (w_aceita && (RegReserva == END'(i))) begin
        w_prox[i] = 1'b1;
      end
      if (ZERO_FIXO && (i == 0)) begin
        w_prox[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ocupado <= '0;
    end else begin
      r_ocupado <= w_prox;
    end
  end

  // A write in flight to the queried register makes its data available now.
  assign Ocupado1 = r_ocupado[Fonte1] & ~Rst
                  & ~(EscA && (RegEscA == Fonte1)) & ~(EscB && (RegEscB == Fonte1));
  assign Ocupado2 = r_ocupado[Fonte2] & ~Rst
                  & ~(EscA && (RegEscA == Fonte2)) & ~(EscB && (RegEscB == Fonte2));

  assign ReservaAceita = w_aceita;

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised register bank: two combinational read ports with write-through
// forwarding, two write ports (B wins on address conflict) and a busy-bit
// scoreboard for destination reservation.
// Ports:
//   Clk, Rst                      clock, asynchronous active-high reset
//   Fonte1/2 -> Dado1/2, Ocupado1/2   read address, data and busy bit
//   EscA/RegEscA/DadoA            write port A
//   EscB/RegEscB/DadoB            write port B (priority over A)
//   Reserva/RegReserva -> ReservaAceita   reservation request and grant
module banco_registradores_param
  import pkg_banco::*;
#(
  parameter int unsigned LARGURA   = LARGURA_PADRAO,
  parameter int unsigned NREG      = NREG_PADRAO,
  parameter bit          ZERO_FIXO = 1'b1,
  localparam int unsigned END      = larg_end(NREG)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [END-1:0]     Fonte1,
  input  logic [END-1:0]     Fonte2,
  output logic [LARGURA-1:0] Dado1,
  output logic [LARGURA-1:0] Dado2,
  output logic               Ocupado1,
  output logic               Ocupado2,
  input  logic               EscA,
  input  logic [END-1:0]     RegEscA,
  input  logic [LARGURA-1:0] DadoA,
  input  logic               EscB,
  input  logic [END-1:0]     RegEscB,
  input  logic [LARGURA-1:0] DadoB,
  input  logic               Reserva,
  input  logic [END-1:0]     RegReserva,
  output logic               ReservaAceita
);

  logic [LARGURA-1:0] r_mem [NREG];
  logic [END-1:0]     w_fonte [2];
  logic [LARGURA-1:0] w_dado [2];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (!(ZERO_FIXO && (i == 0))) begin
          if (EscA && (RegEscA == END'(i))) r_mem[i] <= DadoA;
          // Later assignment wins: port B has priority on a shared target.
          if (EscB && (RegEscB == END'(i))) r_mem[i] <= DadoB;
        end
      end
    end
  end

  assign w_fonte[0] = Fonte1;
  assign w_fonte[1] = Fonte2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_dado[p] = r_mem[w_fonte[p]];
      if (EscA && (RegEscA == w_fonte[p])) w_dado[p] = DadoA;
      if (EscB && (RegEscB == w_fonte[p])) w_dado[p] = DadoB;
      if (ZERO_FIXO && (w_fonte[p] == '0)) w_dado[p] = '0;
      // Forwarded write data must not leak while the bank is held in reset.
      if (Rst) w_dado[p] = '0;
    end
  end

  assign Dado1 = w_dado[0];
  assign Dado2 = w_dado[1];

  placar_ocupado #(
    .NREG      (NREG),
    .ZERO_FIXO (ZERO_FIXO)
  ) u_placar (
    .Clk           (Clk),
    .Rst           (Rst),
    .Fonte1        (Fonte1),
    .Fonte2        (Fonte2),
    .EscA          (EscA),
    .RegEscA       (RegEscA),
    .EscB          (EscB),
    .RegEscB       (RegEscB),
    .Reserva       (Reserva),
    .RegReserva    (RegReserva),
    .Ocupado1      (Ocupado1),
    .Ocupado2      (Ocupado2),
    .ReservaAceita (ReservaAceita)
  );

endmodule

// File: tb/tb_banco_registradores_param.sv
// Scoreboard bench for banco_registradores_param (LARGURA=32, NREG=4, ZERO_FIXO=1).
module tb_banco_registradores_param;

  localparam int SEL_D1 = 0, SEL_D2 = 1, SEL_OC1 = 2, SEL_OC2 = 3, SEL_ACE = 4;

  typedef struct {
    string       nome;
    int          cyc;
    int          sel;
    logic [31:0] esperado;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [1:0]  Fonte1 = '0, Fonte2 = '0, RegEscA = '0, RegEscB = '0, RegReserva = '0;
  logic [31:0] DadoA = '0, DadoB = '0;
  logic        EscA = 1'b0, EscB = 1'b0, Reserva = 1'b0;
  logic [31:0] Dado1, Dado2;
  logic        Ocupado1, Ocupado2, ReservaAceita;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  banco_registradores_param #(
    .LARGURA   (32),
    .NREG      (4),
    .ZERO_FIXO (1'b1)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Fonte1        (Fonte1),
    .Fonte2        (Fonte2),
    .Dado1         (Dado1),
    .Dado2         (Dado2),
    .Ocupado1      (Ocupado1),
    .Ocupado2      (Ocupado2),
    .EscA          (EscA),
    .RegEscA       (RegEscA),
    .DadoA         (DadoA),
    .EscB          (EscB),
    .RegEscB       (RegEscB),
    .DadoB         (DadoB),
    .Reserva       (Reserva),
    .RegReserva    (RegReserva),
    .ReservaAceita (ReservaAceita)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: at each falling edge, compare every expectation for this cycle.
  always @(negedge Clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] atual;
      e = q.pop_front();
      case (e.sel)
        SEL_D1:  atual = Dado1;
        SEL_D2:  atual = Dado2;
        SEL_OC1: atual = {31'b0, Ocupado1};
        SEL_OC2: atual = {31'b0, Ocupado2};
        default: atual = {31'b0, ReservaAceita};
      endcase
      n_vec++;
      if (e.cyc != cyc) begin
        n_err++;
        $display("FAIL %s: expectation from cycle %0d not sampled (now %0d)", e.nome, e.cyc, cyc);
      end else if (atual !== e.esperado) begin
        n_err++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", e.nome, atual, e.esperado);
      end
    end
  end

  task automatic espera(input string nome, input int sel, input logic [31:0] v);
    exp_t e;
    e.nome = nome;
    e.cyc = cyc;
    e.sel = sel;
    e.esperado = v;
    q.push_back(e);
  endtask

  task automatic passo();
    @(posedge Clk);
    #1;
  endtask

  task automatic ocioso();
    EscA = 1'b0;
    EscB = 1'b0;
    Reserva = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Held in reset: forwarding and grants are suppressed.
    passo();
    EscA = 1; RegEscA = 1; DadoA = 32'h5; Fonte1 = 1;
    Reserva = 1; RegReserva = 2; Fonte2 = 2;
    espera("rst_dado1", SEL_D1, 32'h0);
    espera("rst_oc2", SEL_OC2, 32'h0);
    espera("rst_aceita", SEL_ACE, 32'h0);
    passo();
    ocioso();
    Rst = 0;

    // r1 <= 0x048fc24a, bypass then stored.
    passo();
    EscA = 1; RegEscA = 1; DadoA = 32'h048fc24a; Fonte1 = 1;
    espera("byp_r1", SEL_D1, 32'h048fc24a);
    passo();
    ocioso();
    espera("lido_r1", SEL_D1, 32'h048fc24a);
    // Asynchronous reset between edges.
    passo();
    Rst = 1;
    espera("rst_imediato", SEL_D1, 32'h0);
    passo();
    Rst = 0;
    espera("rst_depois", SEL_D1, 32'h0);

    // Write/read r2.
    passo();
    EscA = 1; RegEscA = 2; DadoA = 32'h4; Fonte1 = 2;
    passo();
    ocioso();
    espera("lido_r2", SEL_D1, 32'h4);
    passo();
    EscA = 1; RegEscA = 2; DadoA = 32'h6; Fonte2 = 2;
    espera("byp_r2_p2", SEL_D2, 32'h6);
    espera("byp_r2_p1", SEL_D1, 32'h6);
    passo();
    ocioso();
    espera("lido_r2_novo", SEL_D1, 32'h6);
    espera("oc_r2_livre", SEL_OC2, 32'h0);

    // Dual-write conflict on r3.
    passo();
    EscA = 1; RegEscA = 3; DadoA = 32'h11;
    EscB = 1; RegEscB = 3; DadoB = 32'h22; Fonte1 = 3;
    espera("conflito_byp", SEL_D1, 32'h22);
    passo();
    ocioso();
    espera("conflito_r3", SEL_D1, 32'h22);

    // r0 is fixed at zero and cannot be reserved.
    passo();
    EscA = 1; RegEscA = 0; DadoA = 32'hFFFFFFFF;
    EscB = 1; RegEscB = 0; DadoB = 32'hFFFFFFFF; Fonte1 = 0;
    Reserva = 1; RegReserva = 0;
    espera("r0_byp", SEL_D1, 32'h0);
    espera("r0_reserva", SEL_ACE, 32'h0);
    passo();
    ocioso();
    Fonte2 = 0;
    espera("r0_lido", SEL_D1, 32'h0);
    espera("r0_ocupado", SEL_OC2, 32'h0);

    // Scoreboard on r1.
    passo();
    Reserva = 1; RegReserva = 1; Fonte1 = 1; Fonte2 = 1;
    espera("res1_aceita", SEL_ACE, 32'h1);
    espera("res1_oc_antes", SEL_OC1, 32'h0);
    passo();
    espera("res1_rejeita", SEL_ACE, 32'h0);
    espera("res1_oc1", SEL_OC1, 32'h1);
    espera("res1_oc2", SEL_OC2, 32'h1);
    espera("res1_dado", SEL_D1, 32'h0);
    passo();
    ocioso();
    EscA = 1; RegEscA = 1; DadoA = 32'h77;
    espera("lib_oc_comb", SEL_OC1, 32'h0);
    espera("lib_dado", SEL_D1, 32'h77);
    passo();
    ocioso();
    espera("lib_oc_reg", SEL_OC1, 32'h0);
    espera("lib_valor", SEL_D1, 32'h77);
    // Simultaneous write and accepted reservation: bit stays set.
    passo();
    EscB = 1; RegEscB = 1; DadoB = 32'h99;
    Reserva = 1; RegReserva = 1;
    espera("sim_aceita", SEL_ACE, 32'h1);
    espera("sim_oc_comb", SEL_OC1, 32'h0);
    passo();
    ocioso();
    espera("sim_oc_reg", SEL_OC1, 32'h1);
    espera("sim_dado", SEL_D1, 32'h99);

    passo();
    passo();
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL fila: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
